// File: rtl/seg7_scan_ctrl.sv
// Avalon-MM multiplexed 7-segment scan controller: per-digit value/DP registers,
// hex decode, and a SHOW/BLANK scan FSM with a blank gap between digits.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [2:0]            address,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int unsigned CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [2:0]  ND   = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      idx, idx_d;
  logic            wrap;
  logic [4:0]      digit_q [4];
  logic            ctrl_en, ctrl_pol, frame;
  logic [6:0]      seg_dec;
  logic            wr;
  logic            unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^{writedata[31:9], writedata[7:5]};

  // Register file; digit slots beyond NUM_DIGITS stay at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned d = 0; d < 4; d++) digit_q[d] <= '0;
      ctrl_en  <= 1'b0;
      ctrl_pol <= 1'b1;
      frame    <= 1'b0;
    end else begin
      for (int unsigned d = 0; d < 4; d++)
        if (wr && address == 3'(d) && d < NUM_DIGITS) digit_q[d] <= writedata[4:0];
      if (wr && address == 3'd4) begin
        ctrl_en  <= writedata[0];
        ctrl_pol <= writedata[1];
      end
      if (wrap)
        frame <= 1'b1;
      else if (wr && address == 3'd5 && writedata[8])
        frame <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0, 3'd1, 3'd2, 3'd3:
        if (address < ND) readdata[4:0] = digit_q[address[1:0]];
      3'd4:    readdata[1:0] = {ctrl_pol, ctrl_en};
      3'd5:    begin
        readdata[1:0] = idx;
        readdata[8]   = frame;
      end
      default: readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    wrap    = 1'b0;
    if (!ctrl_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = '0;
        end
        SHOW: begin
          if (cnt == CW'(PRESCALE - 1)) begin
            cnt_d = '0;
            if (BLANK_CYCLES > 0) begin
              state_d = BLANK;
            end else if (idx == 2'(NUM_DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx + 2'd1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        BLANK: begin
          if (cnt == CW'(BLANK_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = SHOW;
            if (idx == 2'(NUM_DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx + 2'd1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    seg_dec = 7'h00;
    case (digit_q[idx][3:0])
      4'h0: seg_dec = 7'h3F;
      4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;
      4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;
      4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;
      4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h6F;
      4'hA: seg_dec = 7'h77;
      4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;
      4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;
      4'hF: seg_dec = 7'h71;
      default: seg_dec = 7'h00;
    endcase
  end

  // Outputs are registered from the pre-edge state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit_en <= '0;
      seg_out  <= 7'h7F;
      dp_out   <= 1'b1;
    end else if (state == SHOW) begin
      digit_en <= NUM_DIGITS'(1) << idx;
      seg_out  <= seg_dec ^ {7{ctrl_pol}};
      dp_out   <= digit_q[idx][4] ^ ctrl_pol;
    end else begin
      digit_en <= '0;
      seg_out  <= {7{ctrl_pol}};
      dp_out   <= ctrl_pol;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, dwell 4, blank 2) plus a 2-digit
// instance for the unimplemented-digit register behaviour.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic [31:0] readdata2;
  logic [6:0]  unused_seg2;
  logic        unused_dp2;
  logic [1:0]  unused_en2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] seg_exp [4];
  logic       dp_exp  [4];

  seg7_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_out(seg_out), .dp_out(dp_out), .digit_en(digit_en)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(2), .PRESCALE(4), .BLANK_CYCLES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .seg_out(unused_seg2), .dp_out(unused_dp2), .digit_en(unused_en2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic wait_for(input string tag, input logic [3:0] v);
    for (int i = 0; i < 64 && digit_en !== v; i++) @(negedge clk);
    chk(tag, {28'd0, digit_en}, {28'd0, v});
  endtask

  initial begin
    seg_exp = '{7'h79, 7'h24, 7'h08, 7'h0E};
    dp_exp  = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_seg", {25'd0, seg_out}, 32'h7F);
    chk("rst_dp", {31'd0, dp_out}, 32'h1);
    chk("rst_en", {28'd0, digit_en}, 32'h0);
    for (int a = 0; a < 8; a++)
      rd($sformatf("rst_rd%0d", a), 3'(a), (a == 4) ? 32'h2 : 32'h0);
    @(negedge clk);

    // Scan of four programmed digits, one full 24-cycle frame
    wr(3'd0, 32'h01);
    wr(3'd1, 32'h12);
    wr(3'd2, 32'h0A);
    wr(3'd3, 32'h1F);
    rd("rd_digit1", 3'd1, 32'h12);
    wr(3'd4, 32'h3);
    wait_for("start_d0", 4'h1);
    for (int j = 0; j < 24; j++) begin
      if (j % 6 < 4) begin
        chk($sformatf("scan%0d_en", j), {28'd0, digit_en}, 32'(4'h1 << (j / 6)));
        chk($sformatf("scan%0d_seg", j), {25'd0, seg_out}, {25'd0, seg_exp[j / 6]});
        chk($sformatf("scan%0d_dp", j), {31'd0, dp_out}, {31'd0, dp_exp[j / 6]});
      end else begin
        chk($sformatf("blank%0d_en", j), {28'd0, digit_en}, 32'h0);
        chk($sformatf("blank%0d_seg", j), {25'd0, seg_out}, 32'h7F);
        chk($sformatf("blank%0d_dp", j), {31'd0, dp_out}, 32'h1);
      end
      @(negedge clk);
    end

    // FRAME sticky, set-wins on the wrap cycle, clear elsewhere
    rd("frame_set", 3'd5, 32'h100);
    wait_for("sync_d3", 4'h8);
    wait_for("sync_blank3", 4'h0);
    wr(3'd5, 32'h100);
    rd("frame_setwins", 3'd5, 32'h100);
    wr(3'd5, 32'h100);
    rd("frame_clr", 3'd5, 32'h0);

    // Polarity switch mid-SHOW of digit 2, then disable
    wait_for("sync_d2", 4'h4);
    wr(3'd4, 32'h1);
    chk("pol_old_en", {28'd0, digit_en}, 32'h4);
    chk("pol_old_seg", {25'd0, seg_out}, 32'h08);
    chk("pol_old_dp", {31'd0, dp_out}, 32'h1);
    @(negedge clk);
    chk("pol_new_en", {28'd0, digit_en}, 32'h4);
    chk("pol_new_seg", {25'd0, seg_out}, 32'h77);
    chk("pol_new_dp", {31'd0, dp_out}, 32'h0);
    wr(3'd4, 32'h0);
    repeat (2) @(negedge clk);
    chk("idle_en", {28'd0, digit_en}, 32'h0);
    chk("idle_seg", {25'd0, seg_out}, 32'h00);
    chk("idle_dp", {31'd0, dp_out}, 32'h0);
    rd("idle_status", 3'd5, 32'h0);
    @(negedge clk);

    // Synchronous reset mid-BLANK of digit 3
    wr(3'd4, 32'h3);
    wait_for("sync2_d3", 4'h8);
    wait_for("sync2_blank3", 4'h0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst2_en", {28'd0, digit_en}, 32'h0);
    chk("rst2_seg", {25'd0, seg_out}, 32'h7F);
    chk("rst2_dp", {31'd0, dp_out}, 32'h1);
    for (int a = 0; a < 6; a++)
      rd($sformatf("rst2_rd%0d", a), 3'(a), (a == 4) ? 32'h2 : 32'h0);
    @(negedge clk);
    wr(3'd4, 32'h3);
    chk("restart_lat0", {28'd0, digit_en}, 32'h0);
    @(negedge clk);
    chk("restart_lat1", {28'd0, digit_en}, 32'h0);
    @(negedge clk);
    chk("restart_en", {28'd0, digit_en}, 32'h1);
    chk("restart_seg", {25'd0, seg_out}, 32'h40);
    chk("restart_dp", {31'd0, dp_out}, 32'h1);
    rd("restart_status", 3'd5, 32'h0);
    @(negedge clk);

    // Reserved address and unimplemented digit on the 2-digit build
    wr(3'd6, 32'hFFFF_FFFF);
    rd("rsvd6", 3'd6, 32'h0);
    wr(3'd3, 32'h1F);
    rd("d3_4dig", 3'd3, 32'h1F);
    chk("d3_2dig", readdata2, 32'h0);
    wr(3'd0, 32'hFFFF_FFEA);
    rd("d0_mask", 3'd0, 32'h0A);
    chk("d0_2dig", readdata2, 32'h0A);
    address = 3'd7;
    #1;
    chk("rsvd7_2dig", readdata2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
